// File: rtl/rs_pkg.sv
// Shared reservation-station types and decode constants, used by every
// functional-unit station and by the dispatch decoder.
package rs_pkg;

    localparam int DEF_XLEN   = 32;
    localparam int DEF_PREG_W = 8;

    localparam logic [6:0] OPCODE_RTYPE  = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef struct packed {
        logic                  valid;
        logic                  rdy1;
        logic                  rdy2;
        logic [DEF_XLEN-1:0]   op1;
        logic [DEF_XLEN-1:0]   op2;
        logic [DEF_PREG_W-1:0] tag1;
        logic [DEF_PREG_W-1:0] tag2;
        logic [2:0]            func3;
        logic [3:0]            aluop;
        logic [DEF_XLEN-1:0]   pc;
        logic [DEF_PREG_W-1:0] rd;
        logic [31:0]           inst_num;
    } rs_entry_t;

endpackage

// File: rtl/rs_oldest_select.sv
// Picks the requesting entry with the smallest program-order number using a
// binary comparator tree; DEPTH must be a power of two.
module rs_oldest_select #(
    parameter int DEPTH = 4,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]       req_i,
    input  logic [DEPTH-1:0][31:0] inst_num_i,
    output logic [IDX_W-1:0]       idx_o,
    output logic                   found_o
);

    always_comb begin
        logic             nv [2*DEPTH-1];
        logic [IDX_W-1:0] ni [2*DEPTH-1];
        logic [31:0]      nn [2*DEPTH-1];
        for (int i = 0; i < 2*DEPTH-1; i++) begin
            nv[i] = 1'b0;
            ni[i] = '0;
            nn[i] = '0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            nv[DEPTH-1+i] = req_i[i];
            ni[DEPTH-1+i] = IDX_W'(i);
            nn[DEPTH-1+i] = inst_num_i[i];
        end
        // Heap layout: node n has children 2n+1 and 2n+2, leaves at the tail.
        for (int n = DEPTH-2; n >= 0; n--) begin
            if (nv[2*n+1] && (!nv[2*n+2] || nn[2*n+1] < nn[2*n+2])) begin
                nv[n] = 1'b1;
                ni[n] = ni[2*n+1];
                nn[n] = nn[2*n+1];
            end else begin
                nv[n] = nv[2*n+2];
                ni[n] = ni[2*n+2];
                nn[n] = nn[2*n+2];
            end
        end
        idx_o   = ni[0];
        found_o = nv[0];
    end

endmodule

// File: rtl/mul_reservation_station.sv
// MUL-class reservation station: buffers dispatched ops, captures operands
// from the CDB and issues the oldest ready op through a registered port.
module mul_reservation_station
    import rs_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int XLEN   = DEF_XLEN,
    parameter int PREG_W = DEF_PREG_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       mul_rs_on,
    input  logic [XLEN-1:0]            mul_alu_operand1,
    input  logic [XLEN-1:0]            mul_alu_operand2,
    input  logic [2:0]                 mul_alu_func3,
    input  logic [XLEN-1:0]            mul_alu_pc,
    input  logic [PREG_W-1:0]          mul_rd_phy_reg,
    input  logic [PREG_W-1:0]          mul_operand1_phy,
    input  logic [PREG_W-1:0]          mul_operand2_phy,
    input  logic [1:0]                 mul_valid,
    input  logic [3:0]                 mul_aluop,
    input  logic [31:0]                mul_inst_num,
    input  logic                       cdb_valid,
    input  logic [PREG_W-1:0]          cdb_phy,
    input  logic [XLEN-1:0]            cdb_data,
    output logic                       rs_full,
    output logic [$clog2(DEPTH):0]     rs_count,
    output logic                       rs_overflow,
    output logic                       issue_valid,
    input  logic                       issue_ready,
    output logic [XLEN-1:0]            issue_operand1,
    output logic [XLEN-1:0]            issue_operand2,
    output logic [2:0]                 issue_func3,
    output logic [3:0]                 issue_aluop,
    output logic [XLEN-1:0]            issue_pc,
    output logic [PREG_W-1:0]          issue_rd_phy,
    output logic [31:0]                issue_inst_num
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    rs_entry_t              ent_q [DEPTH];
    rs_entry_t              ent_d [DEPTH];
    rs_entry_t              disp_ent;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   overflow_q;
    logic                   iss_valid_q;
    logic [XLEN-1:0]        iss_op1_q, iss_op2_q, iss_pc_q;
    logic [2:0]             iss_func3_q;
    logic [3:0]             iss_aluop_q;
    logic [PREG_W-1:0]      iss_rd_q;
    logic [31:0]            iss_inst_q;

    logic [DEPTH-1:0]       req;
    logic [DEPTH-1:0][31:0] inst_nums;
    logic [IDX_W-1:0]       sel_idx, free_idx;
    logic                   sel_found, dispatch, issue_load;

    assign rs_full    = (count_q == CNT_W'(DEPTH));
    assign dispatch   = mul_rs_on && !rs_full && !flush;
    assign issue_load = !flush && sel_found && (!iss_valid_q || issue_ready);
    assign count_d    = flush ? '0 : count_q + CNT_W'(dispatch) - CNT_W'(issue_load);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            req[i]       = ent_q[i].valid && ent_q[i].rdy1 && ent_q[i].rdy2;
            inst_nums[i] = ent_q[i].inst_num;
        end
    end

    rs_oldest_select #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_select (
        .req_i      (req),
        .inst_num_i (inst_nums),
        .idx_o      (sel_idx),
        .found_o    (sel_found)
    );

    always_comb begin
        free_idx = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (!ent_q[i].valid) free_idx = IDX_W'(i);
        end
    end

    // A not-yet-ready source can be satisfied by the broadcast on the dispatch edge.
    always_comb begin
        disp_ent          = '0;
        disp_ent.valid    = 1'b1;
        disp_ent.rdy1     = mul_valid[1];
        disp_ent.rdy2     = mul_valid[0];
        disp_ent.op1      = mul_alu_operand1;
        disp_ent.op2      = mul_alu_operand2;
        disp_ent.tag1     = mul_operand1_phy;
        disp_ent.tag2     = mul_operand2_phy;
        disp_ent.func3    = mul_alu_func3;
        disp_ent.aluop    = mul_aluop;
        disp_ent.pc       = mul_alu_pc;
        disp_ent.rd       = mul_rd_phy_reg;
        disp_ent.inst_num = mul_inst_num;
        if (!mul_valid[1] && cdb_valid && mul_operand1_phy == cdb_phy) begin
            disp_ent.rdy1 = 1'b1;
            disp_ent.op1  = cdb_data;
        end
        if (!mul_valid[0] && cdb_valid && mul_operand2_phy == cdb_phy) begin
            disp_ent.rdy2 = 1'b1;
            disp_ent.op2  = cdb_data;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
            if (ent_q[i].valid && cdb_valid && !ent_q[i].rdy1 && ent_q[i].tag1 == cdb_phy) begin
                ent_d[i].rdy1 = 1'b1;
                ent_d[i].op1  = cdb_data;
            end
            if (ent_q[i].valid && cdb_valid && !ent_q[i].rdy2 && ent_q[i].tag2 == cdb_phy) begin
                ent_d[i].rdy2 = 1'b1;
                ent_d[i].op2  = cdb_data;
            end
        end
        if (issue_load) ent_d[sel_idx].valid = 1'b0;
        if (dispatch)   ent_d[free_idx] = disp_ent;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) ent_d[i].valid = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            iss_valid_q <= 1'b0;
            iss_op1_q   <= '0;
            iss_op2_q   <= '0;
            iss_func3_q <= '0;
            iss_aluop_q <= '0;
            iss_pc_q    <= '0;
            iss_rd_q    <= '0;
            iss_inst_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
            count_q <= count_d;
            if (mul_rs_on && rs_full) overflow_q <= 1'b1;
            if (flush) begin
                iss_valid_q <= 1'b0;
            end else if (issue_load) begin
                iss_valid_q <= 1'b1;
                iss_op1_q   <= ent_q[sel_idx].op1;
                iss_op2_q   <= ent_q[sel_idx].op2;
                iss_func3_q <= ent_q[sel_idx].func3;
                iss_aluop_q <= ent_q[sel_idx].aluop;
                iss_pc_q    <= ent_q[sel_idx].pc;
                iss_rd_q    <= ent_q[sel_idx].rd;
                iss_inst_q  <= ent_q[sel_idx].inst_num;
            end else if (issue_ready) begin
                iss_valid_q <= 1'b0;
            end
        end
    end

    assign rs_count       = count_q;
    assign rs_overflow    = overflow_q;
    assign issue_valid    = iss_valid_q;
    assign issue_operand1 = iss_op1_q;
    assign issue_operand2 = iss_op2_q;
    assign issue_func3    = iss_func3_q;
    assign issue_aluop    = iss_aluop_q;
    assign issue_pc       = iss_pc_q;
    assign issue_rd_phy   = iss_rd_q;
    assign issue_inst_num = iss_inst_q;

endmodule

// File: doc/mul_reservation_station.md
Name: mul_reservation_station

Overview:
- Receiving end of the dispatch path: accepts MUL-class micro-ops on `mul_rs_on` from the dispatch decoder and buffers them.
- Captures missing source operands by snooping the common data bus (CDB).
- Issues the oldest operand-ready entry to the multiplier through a registered valid/ready port.
- Sits between dispatch and the MUL ALU; the same block is instantiated per functional unit.

Parameters:
- DEPTH, 4, number of entries (power of 2, ≥2)
- XLEN, 32, operand and data width
- PREG_W, 8, physical register tag width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous squash of all contents (branch mispredict)
- mul_rs_on  in  1  dispatch strobe
- mul_alu_operand1  in  XLEN  source 1 value (meaningful when ready)
- mul_alu_operand2  in  XLEN  source 2 value
- mul_alu_func3  in  3  func3
- mul_alu_pc  in  XLEN  pc
- mul_rd_phy_reg  in  PREG_W  destination tag
- mul_operand1_phy  in  PREG_W  source 1 tag
- mul_operand2_phy  in  PREG_W  source 2 tag
- mul_valid  in  2  [1] = op1 ready, [0] = op2 ready
- mul_aluop  in  4  ALUOP
- mul_inst_num  in  32  program-order sequence number
- cdb_valid  in  1  CDB broadcast valid
- cdb_phy  in  PREG_W  broadcast tag
- cdb_data  in  XLEN  broadcast value
- rs_full  out  1  no free entry
- rs_count  out  $clog2(DEPTH)+1  occupied entries
- rs_overflow  out  1  sticky: dispatch while full
- issue_valid  out  1  issue register holds an op
- issue_ready  in  1  MUL unit accepts
- issue_operand1  out  XLEN  issued source 1 value
- issue_operand2  out  XLEN  issued source 2 value
- issue_func3  out  3  issued func3
- issue_aluop  out  4  issued ALUOP
- issue_pc  out  XLEN  issued pc
- issue_rd_phy  out  PREG_W  issued destination tag
- issue_inst_num  out  32  issued sequence number

Behaviour:
- Reset (asynchronous, active-high): all entry valid bits = 0. Outputs: issue_valid=0, all issue_* data=0, rs_count=0, rs_full=0, rs_overflow=0. Reset mid-operation discards everything.
- Entry fields: valid, rdy1, rdy2, op1, op2, tag1, tag2, func3, aluop, pc, rd, inst_num.
- rs_full = (rs_count == DEPTH). It is combinational from registered state only; a slot freed by issue this cycle is not reusable this cycle.
- Dispatch when mul_rs_on && !rs_full && !flush: write the lowest-index free slot at the edge.
  - Readiness of each operand comes from mul_valid.
  - Same-cycle bypass: if an operand is not ready, cdb_valid=1, and its tag == cdb_phy, capture cdb_data and set it ready on the same edge.
- Dispatch when mul_rs_on && rs_full: dropped; rs_overflow is set and held until reset.
- Wakeup, every edge: each valid entry with rdyX=0 and tagX == cdb_phy (cdb_valid=1) captures cdb_data into opX and sets rdyX=1. Both operands can wake on the same broadcast.
- Select (combinational): among entries with valid && rdy1 && rdy2, pick the smallest inst_num. Ties cannot occur.
- inst_num is treated as monotonic unsigned; wrap-around is not supported.
- Issue register loads when (!issue_valid || issue_ready) and a selected entry exists. The selected entry is freed on the same edge.
- If nothing is selected and issue_ready=1, issue_valid drops to 0.
- While issue_valid && !issue_ready, all issue_* outputs hold stable.
- Latency: an op dispatched ready at edge k is visible on issue_* after edge k+1. An op woken by CDB at edge k issues at edge k+1. Sustained throughput is 1 op/cycle.
- An entry woken in the same cycle it is selected is not possible; selection uses registered ready bits.
- flush (synchronous): clears all entry valid bits and issue_valid, and blocks same-cycle dispatch. rs_overflow is unaffected. flush has priority over dispatch, wakeup and issue.
- rs_count = popcount of entry valid bits. It is a registered count, updated by +dispatch −issue per edge.

Decomposition:
- Shared package rs_pkg:
  - rs_entry_t struct
  - XLEN and PREG_W defaults
  - OPCODE_RTYPE and FUNCT7_MULDIV constants, shared with the dispatch decoder
- One sub-module, rs_oldest_select: combinational ready-mask plus inst_num comparator tree, returning index and found. It is reused by the add/div/branch stations.

Test Plan:
- Reset, then dispatch op1=7, op2=6, valid=2'b11, rd=5, inst=10, issue_ready=1 → one cycle later issue_valid=1, operands 7/6, rd=5; rs_count returns to 0.
- Dispatch valid=2'b01 with tag1=9, then a CDB broadcast 9/0x55 two cycles later → no issue before the broadcast; issue one cycle after, with issue_operand1=0x55.
- Dispatch inst 20, then inst 12, both ready, with issue_ready=0 for 3 cycles → inst 20 holds on the port with stable data; after ready, inst 12 follows.
- Fill 4 entries, none ready → rs_full=1. A 5th mul_rs_on sets rs_overflow=1 and rs_count stays 4.
- Dispatch an entry needing tag 3 while cdb_valid=1 with cdb_phy=3 in the same cycle → entry captures cdb_data and issues the next cycle.
- 3 entries held plus issue_valid=1, then assert flush together with mul_rs_on → rs_count=0 and issue_valid=0 next cycle; the dispatched op is not stored.
